param_sub_sequencer: RTL and testbench
======================================

Name: param_sub_sequencer

Overview:
- Multi-precision subtraction controller. Sequences one WIDTH-bit `param_subtractor` slice over NWORDS words, least-significant word first, chaining borrow between cycles.
- Computes a 32/64-bit class difference from a narrow, area-cheap subtractor.
- Sits between an operand source and a result sink. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, bit width of the shared subtractor slice and of one word.
- NWORDS, 4, number of words per operand; total operand width is WIDTH*NWORDS; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair a_in/b_in is valid.
- in_ready  output  1  sequencer can accept operands.
- a_in  input  WIDTH*NWORDS  minuend.
- b_in  input  WIDTH*NWORDS  subtrahend.
- out_valid  output  1  diff_out/borrow_out are valid.
- out_ready  input  1  sink accepts the result.
- diff_out  output  WIDTH*NWORDS  a_in - b_in, modulo 2^(WIDTH*NWORDS).
- borrow_out  output  1  1 when a_in < b_in (unsigned).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff_out=0, borrow_out=0, word index=0, borrow register=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a_in/b_in into internal registers, clear index and borrow, go to RUN.
  - RUN: in_ready=0. Each cycle, process word[idx] as follows.
    - s = a[idx] - b[idx] from the slice; sb = slice borrow.
    - word result = s - bin.
    - bout = sb | (bin & (s==0)).
    - Write the word result into diff register slice idx; bin <= bout; idx++.
    - At idx==NWORDS-1: borrow_out <= bout, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE; out_valid drops next cycle.
- Latency: out_valid rises exactly NWORDS clock edges after the accepting edge.
- Throughput: minimum one result per NWORDS+2 cycles. There is no same-cycle bypass of DONE->IDLE->accept.
- Operand capture: later changes on a_in/b_in have no effect on an operation in flight.
- Backpressure: diff_out/borrow_out stay stable while out_valid & !out_ready.
- diff_out holds its last value after the handshake until the next write.
- in_valid in RUN/DONE is ignored; no operand is dropped, because in_ready=0.
- NWORDS=1: RUN lasts one cycle. The index counter width is max(1, $clog2(NWORDS)).
- Reset mid-operation: aborts immediately, outputs return to reset values, no partial result is emitted.
- Arithmetic is unsigned only; there is no overflow flag.

Decomposition:
- Shared package `sub_seq_pkg`: state enum {IDLE, RUN, DONE}, 2-bit encoding; index-width helper function.
- One sub-module: the existing `param_subtractor` (ports a, b, diff, borrow), instantiated once with WIDTH. It has no borrow-in, so the borrow-in correction lives in the sequencer.
- Word mux/demux and the borrow register live in the sequencer.

Test Plan:
- WIDTH=8, NWORDS=4 for all scenarios.
1. a=0xFFFFFFFF, b=0xAAAAAAAA, out_ready=1 -> diff=0x55555555, borrow=0, out_valid exactly 4 edges after accept.
2. a=0x00000000, b=0x000000FF -> diff=0xFFFFFF01, borrow=1; borrow propagates through all words.
3. a=0x00010000, b=0x00000001 -> diff=0x0000FFFF, borrow=0. Exercises the s==0 & bin correction in word1 and borrow termination in word2.
4. Backpressure: scenario 1 with out_ready=0 for 5 cycles after out_valid, pulsing in_valid with a new pair. Outputs hold 0x55555555/0 and in_ready stays 0. After out_ready=1, the held pair is accepted only once in_ready=1.
5. Reset: assert rst_n=0 on the 2nd RUN cycle -> out_valid=0, diff_out=0, state IDLE; after release in_ready=1 and no stale result ever appears.
6. Back-to-back: in_valid=1 and out_ready=1 held, operand sets (0xFFFFFFFF,0xAAAAAAAA) then (0,0xFF). Results appear in order with a 6-cycle period, matching a reference model.

Source files
------------

// File: rtl/sub_seq_pkg.sv
// Shared types for the multi-precision subtract sequencer: FSM state encoding and
// the word-index width helper.
package sub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-word operand still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_subtractor.sv
// Combinational WIDTH-bit unsigned subtractor slice with borrow out; no borrow in.
// Zero latency, no flow control.
module param_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/param_sub_sequencer.sv
// Word-serial WIDTH*NWORDS subtractor: out_valid rises NWORDS edges after accept.
// Backpressure holds DONE with stable outputs; in_ready is low until the result leaves.
module param_sub_sequencer
  import sub_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*NWORDS-1:0] a_in,
  input  logic [WIDTH*NWORDS-1:0] b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*NWORDS-1:0] diff_out,
  output logic                    borrow_out
);

  localparam int TW = WIDTH * NWORDS;
  localparam int IW = idx_width(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t          state, state_nxt;
  logic [TW-1:0]   a_q, b_q, diff_q;
  logic [IW-1:0]   idx;
  logic            bin, borrow_q;
  logic [WIDTH-1:0] a_w, b_w, s, word;
  logic            sb, bout;

  assign a_w = a_q[idx*WIDTH +: WIDTH];
  assign b_w = b_q[idx*WIDTH +: WIDTH];

  param_subtractor #(.WIDTH(WIDTH)) u_slice (
    .a      (a_w),
    .b      (b_w),
    .diff   (s),
    .borrow (sb)
  );

  // The slice has no borrow-in, so the incoming borrow is folded in here:
  // subtracting 1 from s only borrows further when s is zero.
  assign word = s - WIDTH'(bin);
  assign bout = sb | (bin & (s == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx      <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a_in;
            b_q <= b_in;
            idx <= '0;
            bin <= 1'b0;
          end
        end
        RUN: begin
          diff_q[idx*WIDTH +: WIDTH] <= word;
          bin <= bout;
          idx <= idx + IW'(1);
          if (idx == LAST) borrow_q <= bout;
        end
        default: ;
      endcase
    end
  end

  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_param_sub_sequencer.sv
// Self-checking bench for param_sub_sequencer (WIDTH=8, NWORDS=4): table vectors,
// backpressure/reset/back-to-back sequences and random pairs against a reference model.
module tb_param_sub_sequencer;

  localparam int WIDTH  = 8;
  localparam int NWORDS = 4;
  localparam int TW     = WIDTH * NWORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, borrow_out;
  logic [TW-1:0] a_in, b_in, diff_out;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_sub_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [TW-1:0] diff;
    logic          borrow;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the full operand width.
  function automatic logic [TW:0] ref_sub(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW-1:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, accept it, wait for the result and complete the output handshake.
  task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        output logic [TW-1:0] d, output logic bo, output int lat);
    int n;
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    check("in_ready_in_run", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    lat = n;
    d   = diff_out;
    bo  = borrow_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] d, ra, rb, exp_held;
    logic          bo, seen;
    logic [TW:0]   r;
    int            lat, got, total, k;
    logic [TW-1:0] pa[$], pb[$];
    logic [TW:0]   expq[$];
    int            times[$];

    tbl[0] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FF01, 1'b1};
    tbl[2] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0};
    tbl[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff_out, 0);
    check("reset_borrow", borrow_out, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, d, bo, lat);
      check($sformatf("tbl%0d_diff", i), d, tbl[i].diff);
      check($sformatf("tbl%0d_borrow", i), bo, tbl[i].borrow);
      check($sformatf("tbl%0d_latency", i), lat, NWORDS);
      check($sformatf("tbl%0d_valid_drop", i), out_valid, 0);
      check($sformatf("tbl%0d_diff_held", i), diff_out, tbl[i].diff);
    end

    // Backpressure: result held in DONE while a new pair is offered
    in_valid = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'hAAAA_AAAA; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    check("bp_latency", k, NWORDS);
    in_valid = 1'b1; a_in = 32'h1234_5678; b_in = 32'h0000_0078;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      check($sformatf("bp_hold_diff%0d", i), diff_out, 32'h5555_5555);
      check($sformatf("bp_hold_borrow%0d", i), borrow_out, 0);
      check($sformatf("bp_hold_in_ready%0d", i), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_diff_held", diff_out, 32'h5555_5555);
    run_op(32'h1234_5678, 32'h0000_0078, d, bo, lat);
    check("bp_next_diff", d, 32'h1234_5600);
    check("bp_next_borrow", bo, 0);
    check("bp_next_latency", lat, NWORDS);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin seen |= out_valid; tick(); end
    check("bp_no_duplicate", seen, 0);

    // Reset on the second RUN cycle
    in_valid = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'hAAAA_AAAA;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_diff", diff_out, 0);
    check("rst_mid_borrow", borrow_out, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= out_valid; end
    check("rst_no_stale_result", seen, 0);
    check("rst_in_ready_after", in_ready, 1);

    // Randomized single operations
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = ra;
      if (i % 4 == 1) rb = ra + 1;
      r = ref_sub(ra, rb);
      run_op(ra, rb, d, bo, lat);
      check($sformatf("rand%0d_diff", i), d, r[TW-1:0]);
      check($sformatf("rand%0d_borrow", i), bo, r[TW]);
      check($sformatf("rand%0d_latency", i), lat, NWORDS);
    end

    // Back-to-back with in_valid and out_ready held high
    pa.push_back(32'hFFFF_FFFF); pb.push_back(32'hAAAA_AAAA);
    pa.push_back(32'h0000_0000); pb.push_back(32'h0000_00FF);
    for (int i = 0; i < 6; i++) begin pa.push_back($urandom); pb.push_back($urandom); end
    total = pa.size();
    k = 0; got = 0;
    in_valid = 1'b1; out_ready = 1'b1; a_in = pa[0]; b_in = pb[0];
    for (int cyc = 0; cyc < 300 && got < total; cyc++) begin
      logic acc;
      acc = in_ready && in_valid;
      if (acc) expq.push_back(ref_sub(a_in, b_in));
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("b2b_unexpected_result", out_valid, 0);
        end else begin
          r = expq.pop_front();
          check($sformatf("b2b%0d_diff", got), diff_out, r[TW-1:0]);
          check($sformatf("b2b%0d_borrow", got), borrow_out, r[TW]);
        end
        times.push_back(cyc);
        got++;
      end
      tick();
      if (acc) begin
        k++;
        if (k < total) begin a_in = pa[k]; b_in = pb[k]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_result_count", got, total);
    for (int i = 1; i < times.size(); i++)
      check($sformatf("b2b_period%0d", i), times[i] - times[i-1], NWORDS + 2);

    exp_held = diff_out;
    tick(); tick();
    check("final_idle_valid", out_valid, 0);
    check("final_diff_held", diff_out, exp_held);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
